alu_ctrl_mdu: RTL and testbench

- Second-generation ALU controller for the pipelined MIPS core.
- Registers the ALU control decode into the EX stage.
- Extends the op set beyond add/sub/and/or/slt.
- Adds a multi-cycle multiply/divide sequencer with HI/LO registers; a pipeline stall is raised while a MULT/DIV is in flight.

---
 rtl/alu_ctrl_pkg.sv | 57 +++++
 rtl/alu_ctrl_mdu_if.sv | 30 +++
 rtl/alu_ctrl_mdu_iter.sv | 101 ++++++++++
 rtl/alu_ctrl_mdu.sv | 126 ++++++++++++
 tb/tb_alu_ctrl_mdu.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU controller and its multiply/divide unit.
package alu_ctrl_pkg;

    // Default widths; the top and interface take these as parameter defaults
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_FUNCT_W = 6;
    localparam int DEF_ALUOP_W = 3;
    localparam int DEF_CTRL_W  = 4;

    // ALU control codes driven to the EX stage
    localparam logic [DEF_CTRL_W-1:0] ALU_AND = 4'd0;
    localparam logic [DEF_CTRL_W-1:0] ALU_OR  = 4'd1;
    localparam logic [DEF_CTRL_W-1:0] ALU_ADD = 4'd2;
    localparam logic [DEF_CTRL_W-1:0] ALU_SLL = 4'd3;
    localparam logic [DEF_CTRL_W-1:0] ALU_SRL = 4'd4;
    localparam logic [DEF_CTRL_W-1:0] ALU_LUI = 4'd5;
    localparam logic [DEF_CTRL_W-1:0] ALU_SUB = 4'd6;
    localparam logic [DEF_CTRL_W-1:0] ALU_SLT = 4'd7;
    localparam logic [DEF_CTRL_W-1:0] ALU_NOR = 4'd12;
    localparam logic [DEF_CTRL_W-1:0] ALU_NOP = 4'd15;

    // ALUOp encodings from the main decoder
    localparam logic [DEF_ALUOP_W-1:0] AOP_MEM   = 3'b000;
    localparam logic [DEF_ALUOP_W-1:0] AOP_BEQ   = 3'b001;
    localparam logic [DEF_ALUOP_W-1:0] AOP_RTYPE = 3'b010;
    localparam logic [DEF_ALUOP_W-1:0] AOP_ADDI  = 3'b011;
    localparam logic [DEF_ALUOP_W-1:0] AOP_ANDI  = 3'b100;
    localparam logic [DEF_ALUOP_W-1:0] AOP_ORI   = 3'b101;
    localparam logic [DEF_ALUOP_W-1:0] AOP_LUI   = 3'b110;
    localparam logic [DEF_ALUOP_W-1:0] AOP_SLTI  = 3'b111;

    // R-format funct codes
    localparam logic [DEF_FUNCT_W-1:0] F_SLL   = 6'd0;
    localparam logic [DEF_FUNCT_W-1:0] F_SRL   = 6'd2;
    localparam logic [DEF_FUNCT_W-1:0] F_MFHI  = 6'd16;
    localparam logic [DEF_FUNCT_W-1:0] F_MTHI  = 6'd17;
    localparam logic [DEF_FUNCT_W-1:0] F_MFLO  = 6'd18;
    localparam logic [DEF_FUNCT_W-1:0] F_MTLO  = 6'd19;
    localparam logic [DEF_FUNCT_W-1:0] F_MULT  = 6'd24;
    localparam logic [DEF_FUNCT_W-1:0] F_MULTU = 6'd25;
    localparam logic [DEF_FUNCT_W-1:0] F_DIV   = 6'd26;
    localparam logic [DEF_FUNCT_W-1:0] F_DIVU  = 6'd27;
    localparam logic [DEF_FUNCT_W-1:0] F_ADD   = 6'd32;
    localparam logic [DEF_FUNCT_W-1:0] F_SUB   = 6'd34;
    localparam logic [DEF_FUNCT_W-1:0] F_AND   = 6'd36;
    localparam logic [DEF_FUNCT_W-1:0] F_OR    = 6'd37;
    localparam logic [DEF_FUNCT_W-1:0] F_NOR   = 6'd39;
    localparam logic [DEF_FUNCT_W-1:0] F_SLT   = 6'd42;

    typedef enum logic [1:0] {MULT, MULTU, DIV, DIVU} mduOp_e;

    // funct 24..27 map onto the enum by their two low bits
    function automatic mduOp_e functToMduOp(input logic [1:0] functLow);
        return mduOp_e'(functLow);
    endfunction

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// ID->EX bus of the ALU controller: decode inputs, registered controls, stall and HI/LO.
interface alu_ctrl_mdu_if #(
    parameter int DATA_W  = alu_ctrl_pkg::DEF_DATA_W,
    parameter int FUNCT_W = alu_ctrl_pkg::DEF_FUNCT_W,
    parameter int ALUOP_W = alu_ctrl_pkg::DEF_ALUOP_W,
    parameter int CTRL_W  = alu_ctrl_pkg::DEF_CTRL_W
) ();
    logic               valid_i;
    logic [FUNCT_W-1:0] funct_i;
    logic [ALUOP_W-1:0] ALUOp_i;
    logic [DATA_W-1:0]  src1_i;
    logic [DATA_W-1:0]  src2_i;
    logic [CTRL_W-1:0]  ALUCtrl_o;
    logic               valid_o;
    logic               illegal_o;
    logic               stall_o;
    logic               mdu_done_o;
    logic [DATA_W-1:0]  hi_o;
    logic [DATA_W-1:0]  lo_o;

    modport master (
        output valid_i, funct_i, ALUOp_i, src1_i, src2_i,
        input  ALUCtrl_o, valid_o, illegal_o, stall_o, mdu_done_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, funct_i, ALUOp_i, src1_i, src2_i,
        output ALUCtrl_o, valid_o, illegal_o, stall_o, mdu_done_o, hi_o, lo_o
    );
endinterface

// File: rtl/alu_ctrl_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step per busy cycle.
// Works on operand magnitudes and applies the result signs on the final step.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              busy_i,
    input  mduOp_e            op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              last_o
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]    cnt_q;
    mduOp_e              op_q;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opB_q, rawA_q;
    logic                negRes_q, negRem_q, divZero_q;

    logic                isSigned, s1, s2;
    logic [DATA_W-1:0]   magA, magB;
    logic [DATA_W:0]     mulSum, divShift, divDiff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quot, rem;

    // Operand magnitudes at start; unsigned DATA_W bits already hold the most-negative value's magnitude
    always_comb begin
        isSigned = (op_i == MULT) || (op_i == DIV);
        s1       = isSigned & src1_i[DATA_W-1];
        s2       = isSigned & src2_i[DATA_W-1];
        magA     = s1 ? -src1_i : src1_i;
        magB     = s2 ? -src2_i : src2_i;
    end

    // One iteration: acc holds {product} for multiply, {remainder, quotient} for divide
    always_comb begin
        mulSum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opB_q} : '0);
        divShift = acc_q[2*DATA_W-1:DATA_W-1];
        divDiff  = divShift - {1'b0, opB_q};
        if (op_q == MULT || op_q == MULTU)
            acc_d = {mulSum, acc_q[DATA_W-1:1]};
        else if (!divDiff[DATA_W])
            acc_d = {divDiff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        else
            acc_d = {divShift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end

    // Final HI/LO from the step completing this cycle, sign-corrected
    always_comb begin
        prod = negRes_q ? -acc_d : acc_d;
        quot = negRes_q ? -acc_d[DATA_W-1:0] : acc_d[DATA_W-1:0];
        rem  = negRem_q ? -acc_d[2*DATA_W-1:DATA_W] : acc_d[2*DATA_W-1:DATA_W];
        if (op_q == MULT || op_q == MULTU) begin
            hi_o = prod[2*DATA_W-1:DATA_W];
            lo_o = prod[DATA_W-1:0];
        end else if (divZero_q) begin
            hi_o = rawA_q;
            lo_o = '1;
        end else begin
            hi_o = rem;
            lo_o = quot;
        end
    end

    assign last_o = busy_i && (cnt_q == '0);

    // Latch operands on start, then step and count down while the parent reports busy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            op_q      <= MULT;
            acc_q     <= '0;
            opB_q     <= '0;
            rawA_q    <= '0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
        end else if (start_i) begin
            cnt_q     <= CNT_W'(DATA_W - 1);
            op_q      <= op_i;
            acc_q     <= {{DATA_W{1'b0}}, magA};
            opB_q     <= magB;
            rawA_q    <= src1_i;
            negRes_q  <= s1 ^ s2;
            negRem_q  <= s1;
            divZero_q <= (src2_i == '0);
        end else if (busy_i) begin
            acc_q <= acc_d;
            if (cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU controller with EX-stage register, HI/LO registers and a multi-cycle MULT/DIV sequencer.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FUNCT_W = DEF_FUNCT_W,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int CTRL_W  = DEF_CTRL_W
) (
    input logic           clk_i,
    input logic           rst_i,
    alu_ctrl_mdu_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q;
    logic [CTRL_W-1:0] ctrl_d, ALUCtrl_q;
    logic              illegal_d, decIllegal, valid_q, illegal_q, mduDone_q;
    logic              isMdu, isMthi, isMtlo, mduStart, mduLast, stall;
    logic [DATA_W-1:0] hi_q, lo_q, iterHi, iterLo;

    // ALU control decode from ALUOp and funct; also flags the HI/LO-related R-format ops
    always_comb begin
        ctrl_d     = ALU_NOP;
        decIllegal = 1'b0;
        isMdu      = 1'b0;
        isMthi     = 1'b0;
        isMtlo     = 1'b0;
        case (bus.ALUOp_i)
            AOP_MEM, AOP_ADDI: ctrl_d = ALU_ADD;
            AOP_BEQ:           ctrl_d = ALU_SUB;
            AOP_ANDI:          ctrl_d = ALU_AND;
            AOP_ORI:           ctrl_d = ALU_OR;
            AOP_LUI:           ctrl_d = ALU_LUI;
            AOP_SLTI:          ctrl_d = ALU_SLT;
            AOP_RTYPE: begin
                case (bus.funct_i)
                    F_ADD:  ctrl_d = ALU_ADD;
                    F_SUB:  ctrl_d = ALU_SUB;
                    F_AND:  ctrl_d = ALU_AND;
                    F_OR:   ctrl_d = ALU_OR;
                    F_NOR:  ctrl_d = ALU_NOR;
                    F_SLT:  ctrl_d = ALU_SLT;
                    F_SLL:  ctrl_d = ALU_SLL;
                    F_SRL:  ctrl_d = ALU_SRL;
                    F_MFHI, F_MFLO: ctrl_d = ALU_NOP;
                    F_MTHI: isMthi = 1'b1;
                    F_MTLO: isMtlo = 1'b1;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: isMdu = 1'b1;
                    default: decIllegal = 1'b1;
                endcase
            end
            default: decIllegal = 1'b1;
        endcase
        illegal_d = bus.valid_i & decIllegal;
    end

    assign stall    = (state_q == BUSY);
    assign mduStart = !stall && bus.valid_i && isMdu;

    mdu_iter #(.DATA_W(DATA_W)) u_iter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mduStart),
        .busy_i  (stall),
        .op_i    (functToMduOp(bus.funct_i[1:0])),
        .src1_i  (bus.src1_i),
        .src2_i  (bus.src2_i),
        .hi_o    (iterHi),
        .lo_o    (iterLo),
        .last_o  (mduLast)
    );

    // EX stage register: loads every edge unless the MDU freezes the pipe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ALUCtrl_q <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            ALUCtrl_q <= ctrl_d;
            valid_q   <= bus.valid_i;
            illegal_q <= illegal_d;
        end
    end

    // MDU sequencer FSM: owns HI/LO writes (mthi/mtlo in IDLE, result on the last step) and the done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mduDone_q <= 1'b0;
        end else begin
            mduDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mduStart)
                        state_q <= BUSY;
                    if (bus.valid_i && isMthi)
                        hi_q <= bus.src1_i;
                    if (bus.valid_i && isMtlo)
                        lo_q <= bus.src1_i;
                end
                BUSY: begin
                    if (mduLast) begin
                        hi_q      <= iterHi;
                        lo_q      <= iterLo;
                        mduDone_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ALUCtrl_o  = ALUCtrl_q;
    assign bus.valid_o    = valid_q;
    assign bus.illegal_o  = illegal_q;
    assign bus.stall_o    = stall;
    assign bus.mdu_done_o = mduDone_q;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed bench for alu_ctrl_mdu: decode table plus hand-written MULT/DIV, freeze and reset sequences.
module tb_alu_ctrl_mdu;
    import alu_ctrl_pkg::*;

    typedef struct {
        logic       valid;
        logic [2:0] aluop;
        logic [5:0] funct;
        logic [3:0] expCtrl;
        logic       expIll;
        logic       expValid;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    alu_ctrl_mdu_if bus ();

    alu_ctrl_mdu dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.valid_i = v;
        bus.ALUOp_i = op;
        bus.funct_i = f;
        bus.src1_i  = a;
        bus.src2_i  = b;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Starts one MULT/DIV, measures the stall window and checks HI/LO and the done pulse
    task automatic runMdu(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        int stallCycles;
        int earlyPulses;
        stallCycles = 0;
        earlyPulses = 0;
        applyStimulus(1'b1, AOP_RTYPE, f, a, b);
        tick();
        checkOutput({name, " accept ctrl"}, 32'(bus.ALUCtrl_o), 32'(ALU_NOP));
        checkOutput({name, " accept valid"}, 32'(bus.valid_o), 32'd1);
        applyStimulus(1'b0, AOP_MEM, 6'd0, 32'd0, 32'd0);
        while (bus.stall_o && stallCycles < 200) begin
            stallCycles++;
            if (bus.mdu_done_o) earlyPulses++;
            tick();
        end
        checkOutput({name, " stall len"}, 32'(stallCycles), 32'd32);
        checkOutput({name, " early done"}, 32'(earlyPulses), 32'd0);
        checkOutput({name, " hi"}, bus.hi_o, expHi);
        checkOutput({name, " lo"}, bus.lo_o, expLo);
        checkOutput({name, " done pulse"}, 32'(bus.mdu_done_o), 32'd1);
        tick();
        checkOutput({name, " done low"}, 32'(bus.mdu_done_o), 32'd0);
    endtask

    initial begin
        int guard;
        int pulses;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, AOP_MEM, 6'd0, 32'd0, 32'd0);

        // decode table: {valid, ALUOp, funct, ALUCtrl, illegal, valid_o}
        vecs.push_back('{1'b1, 3'b010, 6'd32, 4'd2,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 6'd34, 4'd6,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 6'd36, 4'd0,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 6'd37, 4'd1,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 6'd39, 4'd12, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 6'd42, 4'd7,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 6'd0,  4'd3,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 6'd2,  4'd4,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b011, 6'd50, 4'd2,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b111, 6'd0,  4'd7,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b001, 6'd0,  4'd6,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b000, 6'd34, 4'd2,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b100, 6'd0,  4'd0,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b101, 6'd0,  4'd1,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b110, 6'd0,  4'd5,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 6'd50, 4'd15, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 6'd50, 4'd15, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 6'd16, 4'd15, 1'b0, 1'b1});

        $display("[TB] reset");
        tick();
        tick();
        checkOutput("rst ctrl",    32'(bus.ALUCtrl_o),  32'd0);
        checkOutput("rst valid",   32'(bus.valid_o),    32'd0);
        checkOutput("rst illegal", 32'(bus.illegal_o),  32'd0);
        checkOutput("rst stall",   32'(bus.stall_o),    32'd0);
        checkOutput("rst done",    32'(bus.mdu_done_o), 32'd0);
        checkOutput("rst hi",      bus.hi_o,            32'd0);
        checkOutput("rst lo",      bus.lo_o,            32'd0);
        rst = 1'b0;

        $display("[TB] decode table");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].aluop, vecs[i].funct, 32'd0, 32'd0);
            tick();
            checkOutput($sformatf("vec%0d ctrl", i),    32'(bus.ALUCtrl_o), 32'(vecs[i].expCtrl));
            checkOutput($sformatf("vec%0d illegal", i), 32'(bus.illegal_o), 32'(vecs[i].expIll));
            checkOutput($sformatf("vec%0d valid", i),   32'(bus.valid_o),   32'(vecs[i].expValid));
        end

        $display("[TB] mtlo/mthi and gated writes");
        applyStimulus(1'b1, AOP_RTYPE, F_MTLO, 32'h0000_1234, 32'd0);
        tick();
        checkOutput("mtlo lo", bus.lo_o, 32'h0000_1234);
        checkOutput("mtlo stall", 32'(bus.stall_o), 32'd0);
        applyStimulus(1'b1, AOP_RTYPE, F_MTHI, 32'h0000_ABCD, 32'd0);
        tick();
        checkOutput("mthi hi", bus.hi_o, 32'h0000_ABCD);
        applyStimulus(1'b0, AOP_RTYPE, F_MTLO, 32'h5555_5555, 32'd0);
        tick();
        checkOutput("mtlo invalid lo", bus.lo_o, 32'h0000_1234);
        applyStimulus(1'b0, AOP_RTYPE, F_MULT, 32'd5, 32'd5);
        tick();
        checkOutput("mult invalid stall", 32'(bus.stall_o), 32'd0);

        $display("[TB] multiply/divide");
        runMdu("mult",     F_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runMdu("multu",    F_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA);
        runMdu("mult min", F_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        runMdu("div",      F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runMdu("divu zero", F_DIVU, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF);

        $display("[TB] freeze while busy");
        applyStimulus(1'b1, AOP_RTYPE, F_DIVU, 32'd100, 32'd7);
        tick();
        checkOutput("hold stall", 32'(bus.stall_o), 32'd1);
        applyStimulus(1'b1, AOP_RTYPE, F_ADD, 32'd0, 32'd0);
        repeat (5) tick();
        checkOutput("hold ctrl mid", 32'(bus.ALUCtrl_o), 32'(ALU_NOP));
        guard = 0;
        while (bus.stall_o && guard < 200) begin
            guard++;
            tick();
        end
        checkOutput("hold timeout", 32'(bus.stall_o), 32'd0);
        checkOutput("hold ctrl at fall", 32'(bus.ALUCtrl_o), 32'(ALU_NOP));
        checkOutput("hold lo", bus.lo_o, 32'd14);
        checkOutput("hold hi", bus.hi_o, 32'd2);
        tick();
        checkOutput("held add loads", 32'(bus.ALUCtrl_o), 32'(ALU_ADD));
        checkOutput("held add no restart", 32'(bus.stall_o), 32'd0);
        applyStimulus(1'b1, AOP_RTYPE, F_MFLO, 32'd0, 32'd0);
        tick();
        checkOutput("mflo ctrl", 32'(bus.ALUCtrl_o), 32'(ALU_NOP));
        checkOutput("mflo lo", bus.lo_o, 32'd14);

        $display("[TB] reset mid-divide");
        applyStimulus(1'b1, AOP_RTYPE, F_DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        applyStimulus(1'b0, AOP_MEM, 6'd0, 32'd0, 32'd0);
        repeat (9) tick();
        checkOutput("abort busy before", 32'(bus.stall_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort stall", 32'(bus.stall_o), 32'd0);
        checkOutput("abort hi", bus.hi_o, 32'd0);
        checkOutput("abort lo", bus.lo_o, 32'd0);
        checkOutput("abort done", 32'(bus.mdu_done_o), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mdu_done_o || bus.stall_o) pulses++;
            tick();
        end
        checkOutput("abort no late activity", 32'(pulses), 32'd0);
        runMdu("mult after abort", F_MULT, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
